mul_reduce_pipe: RTL and testbench



---
 rtl/mul_reduce_pipe.sv | 189 ++++++++++++++++++
 tb/tb_mul_reduce_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_reduce_pipe.sv
// mul_reduce_pipe: three-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU).
//   Stage 1 forms XLEN+1 partial-product rows, stage 2 reduces them to a sum row and a
//   carry row with 7:3 counters, stage 3 does the carry-propagate add and slices the result.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = pipe can advance)
//   op                  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1, rs2            multiplicand, multiplier
//   flush               synchronous kill of every in-flight operation
//   out_valid/out_ready result handshake
//   result              low product word for MUL, high word otherwise
module mul_reduce_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulh   = 2'b01;
  localparam logic [1:0] OpMulhsu = 2'b10;

  localparam int unsigned OpW       = XLEN + 1;
  localparam int unsigned PpW       = 2 * OpW;
  localparam int unsigned NumRows   = OpW;
  localparam int unsigned NumGroups = (NumRows + 6) / 7;
  localparam int unsigned TreeRows  = 7 * NumGroups;
  // Each layer shrinks the row count to about 3/7; 8 layers is far more than 33 rows need.
  localparam int unsigned MaxLayers = 8;

  function automatic logic [2:0] compress7_3(input logic [6:0] bits);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < 7; i++) cnt = cnt + {2'b00, bits[i]};
    return cnt;
  endfunction

  logic v1_q, v2_q, v3_q;
  logic adv, accept;

  // The whole pipe moves together; bubbles are not squeezed out.
  assign adv       = !v3_q || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && adv && !flush;
  assign out_valid = v3_q;

  // Stage 1: partial products
  logic           a_sgn, b_sgn;
  logic [OpW-1:0] a_ext, b_ext;
  logic [PpW-1:0] a_wide;
  logic [PpW-1:0] pp_d [NumRows];
  logic [PpW-1:0] pp_q [NumRows];
  logic [1:0]     op1_q;

  always_comb begin
    a_sgn  = (op == OpMulh) || (op == OpMulhsu);
    b_sgn  = (op == OpMulh);
    a_ext  = {a_sgn & rs1[XLEN-1], rs1};
    b_ext  = {b_sgn & rs2[XLEN-1], rs2};
    a_wide = {{OpW{a_ext[OpW-1]}}, a_ext};
    for (int i = 0; i < NumRows; i++) begin
      pp_d[i] = b_ext[i] ? (a_wide << i) : '0;
    end
    // The top bit of a signed multiplier carries negative weight.
    if (b_sgn) pp_d[NumRows-1] = -pp_d[NumRows-1];
  end

  // Stage 2: 7:3 counter tree down to two rows
  logic [PpW-1:0] sum_d, carry_d, sum_q, carry_q;
  logic [1:0]     op2_q;

  always_comb begin : reduce
    logic [PpW-1:0] tree [MaxLayers+1][TreeRows];
    logic [PpW-1:0] s_row, c1_row, c2_row;
    logic [6:0]     grp;
    logic [2:0]     cnt;
    int unsigned    n, o, k, base;
    for (int l = 0; l <= MaxLayers; l++) begin
      for (int r = 0; r < TreeRows; r++) tree[l][r] = '0;
    end
    for (int r = 0; r < NumRows; r++) tree[0][r] = pp_q[r];
    s_row  = '0;
    c1_row = '0;
    c2_row = '0;
    grp    = '0;
    cnt    = '0;
    o      = 0;
    k      = 0;
    base   = 0;
    n      = NumRows;
    for (int l = 0; l < MaxLayers; l++) begin
      if (n <= 2) begin
        tree[l+1][0] = tree[l][0];
        tree[l+1][1] = tree[l][1];
      end else begin
        o = 0;
        for (int g = 0; g < NumGroups; g++) begin
          base = 7 * g;
          if (base < n) begin
            k = (n - base > 7) ? 7 : n - base;
            if (k <= 2) begin
              // Too few rows to gain anything; carry them into the next layer.
              tree[l+1][o] = tree[l][base];
              if (k == 2) tree[l+1][o+1] = tree[l][base+1];
              o = o + k;
            end else begin
              for (int col = 0; col < PpW; col++) begin
                for (int j = 0; j < 7; j++) grp[j] = (j < k) ? tree[l][base+j][col] : 1'b0;
                cnt         = compress7_3(grp);
                s_row[col]  = cnt[0];
                c1_row[col] = cnt[1];
                c2_row[col] = cnt[2];
              end
              tree[l+1][o]   = s_row;
              tree[l+1][o+1] = c1_row << 1;
              if (k > 3) begin
                tree[l+1][o+2] = c2_row << 2;
                o = o + 3;
              end else begin
                // Three inputs can never set the weight-4 output.
                o = o + 2;
              end
            end
          end
        end
        n = o;
      end
    end
    sum_d   = tree[MaxLayers][0];
    carry_d = tree[MaxLayers][1];
  end

  // Stage 3: carry-propagate add and slice
  logic [PpW-1:0]  prod;
  logic [XLEN-1:0] result_d, result_q;
  logic            unused_prod_hi;

  assign prod           = sum_q + carry_q;
  assign result_d       = (op2_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign unused_prod_hi = ^prod[PpW-1:2*XLEN];
  assign result         = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      for (int i = 0; i < NumRows; i++) pp_q[i] <= '0;
      op1_q    <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else begin
      if (flush) begin
        v1_q <= 1'b0;
        v2_q <= 1'b0;
        v3_q <= 1'b0;
      end else if (adv) begin
        v1_q <= accept;
        v2_q <= v1_q;
        v3_q <= v2_q;
      end
      // Data registers only toggle when real work moves into them.
      if (accept) begin
        pp_q  <= pp_d;
        op1_q <= op;
      end
      if (adv && v1_q) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        op2_q   <= op1_q;
      end
      if (adv && v2_q) begin
        result_q <= result_d;
      end
    end
  end

endmodule

// File: tb/tb_mul_reduce_pipe.sv
// Self-checking bench for mul_reduce_pipe: directed vectors plus a random scoreboard run.
module tb_mul_reduce_pipe;

  localparam int NumRandom = 10000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_reduce_pipe #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .rs1      (rs1),
    .rs2      (rs2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  // ISA-level reference: 64-bit product of the extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    ea = (o == 2'b01 || o == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    eb = (o == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = 64'(ea * eb);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive_idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    op        = 2'b00;
    rs1       = '0;
    rs2       = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    drive_idle();
    in_valid = 1'b1; op = 2'b00; rs1 = 32'd7; rs2 = 32'hFFFFFFFD;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL latency_in_ready: got %b expected 1", in_ready);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== (c == 3)) begin
        errors++;
        $display("FAIL latency_valid edge %0d: got %b expected %b", c, out_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (result !== 32'hFFFFFFEB) begin
          errors++; $display("FAIL latency_result: got %h expected ffffffeb", result);
        end
      end
    end
  endtask

  task automatic test_corners();
    logic [1:0]  ops  [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b10};
    logic [31:0] a_v  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                              32'hFFFFFFFF, 32'h00000002, 32'h80000000};
    logic [31:0] b_v  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                              32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] exp_v[7] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000,
                              32'h00000000, 32'h00000001, 32'h80000000};
    int issued = 0;
    int got    = 0;
    drive_idle();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (issued < 7);
      if (issued < 7) begin
        op = ops[issued]; rs1 = a_v[issued]; rs2 = b_v[issued];
      end
      #1;
      if (in_valid && in_ready) issued++;
      if (out_valid) begin
        checks++;
        if (got >= 7) begin
          errors++; $display("FAIL corner_extra: got result %h expected none", result);
        end else if (result !== exp_v[got]) begin
          errors++; $display("FAIL corner_%0d: got %h expected %h", got, result, exp_v[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 7) begin
      errors++; $display("FAIL corner_count: got %0d expected 7", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v[8] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'd72};
    drive_idle();
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (t < 8);
      op        = 2'b00;
      rs1       = 32'(t + 1);
      rs2       = 32'(t + 2);
      #1;
      if (t < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_in_ready t=%0d: got %b expected 1", t, in_ready);
        end
      end
      checks++;
      if (out_valid !== (t >= 3 && t <= 10)) begin
        errors++;
        $display("FAIL b2b_valid t=%0d: got %b expected %b", t, out_valid, (t >= 3 && t <= 10));
      end
      if (t >= 3 && t <= 10) begin
        checks++;
        if (result !== exp_v[t-3]) begin
          errors++; $display("FAIL b2b_result t=%0d: got %h expected %h", t, result, exp_v[t-3]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_v[6] = '{32'd30, 32'd33, 32'd36, 32'd39, 32'd42, 32'd45};
    int issued = 0;
    int got    = 0;
    drive_idle();
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      out_ready = !(t >= 3 && t <= 6);
      in_valid  = (issued < 6);
      op        = 2'b00;
      rs1       = 32'(10 + issued);
      rs2       = 32'd3;
      #1;
      if (t >= 3 && t <= 6) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready t=%0d: got %b expected 0", t, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_valid t=%0d: got %b expected 1", t, out_valid);
        end
        checks++;
        if (result !== 32'd30) begin
          errors++; $display("FAIL stall_hold t=%0d: got %h expected 0000001e", t, result);
        end
      end
      if (in_valid && in_ready) issued++;
      if (out_valid && out_ready) begin
        checks++;
        if (got >= 6) begin
          errors++; $display("FAIL stall_extra: got result %h expected none", result);
        end else if (result !== exp_v[got]) begin
          errors++; $display("FAIL stall_order_%0d: got %h expected %h", got, result, exp_v[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 6) begin
      errors++; $display("FAIL stall_count: got %0d expected 6", got);
    end
  endtask

  task automatic test_flush();
    drive_idle();
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      out_ready = 1'b1;
      flush     = (t == 3);
      in_valid  = (t <= 3) || (t == 10);
      op        = (t == 10) ? 2'b11 : 2'b00;
      rs1       = (t == 10) ? 32'h00010000 : 32'(100 + t);
      rs2       = (t == 10) ? 32'h00010001 : 32'd5;
      #1;
      if (t == 3) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL flush_full: got out_valid %b expected 1", out_valid);
        end
      end else if (t >= 4) begin
        checks++;
        if (out_valid !== (t == 13)) begin
          errors++;
          $display("FAIL flush_valid t=%0d: got %b expected %b", t, out_valid, (t == 13));
        end
        if (t == 13) begin
          checks++;
          if (result !== 32'h00000001) begin
            errors++; $display("FAIL flush_new_op: got %h expected 00000001", result);
          end
        end
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    drive_idle();
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      in_valid = (t < 4);
      op       = 2'b00;
      rs1      = 32'(3 + t);
      rs2      = 32'd7;
    end
    #1;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd28) begin
      errors++;
      $display("FAIL arst_pre: got valid %b result %h expected 1 0000001c", out_valid, result);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL arst_clear: got valid %b ready %b result %h expected 0 1 00000000",
               out_valid, in_ready, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL arst_stale t=%0d: got %b expected 0", t, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] expq[$];
    logic [31:0] specials[6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                                 32'hFFFFFFFE};
    logic [31:0] exp_r;
    int issued = 0;
    int got    = 0;
    drive_idle();
    for (int t = 0; t < 60000 && got < NumRandom; t++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (issued < NumRandom) && ($urandom_range(0, 3) != 0);
      op        = 2'($urandom_range(0, 3));
      rs1       = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      rs2       = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 5)] : $urandom();
      #1;
      if (in_valid && in_ready) begin
        expq.push_back(ref_mul(op, rs1, rs2));
        issued++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rand_extra: got result %h expected none", result);
        end else begin
          exp_r = expq.pop_front();
          if (result !== exp_r) begin
            errors++; $display("FAIL rand_%0d: got %h expected %h", got, result, exp_r);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != NumRandom || expq.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d results (%0d pending) expected %0d", got, expq.size(),
               NumRandom);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
